// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the unified-memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned InstAddrBus       = 32;
  localparam int unsigned InstBus           = 32;
  localparam int unsigned ArbTimeoutDefault = 255;
  localparam int unsigned WdogW             = 16;
  localparam int unsigned SelW              = 4;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_t;

  typedef enum logic {
    GrantIf = 1'b0,
    GrantDm = 1'b1
  } arb_grant_t;

  // Control half of a memory command (address/data travel separately).
  typedef struct packed {
    logic            we;
    logic [SelW-1:0] sel;
  } mem_ctl_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// CPU fetch/data ports and the shared memory port seen by the arbiter.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = InstBus
);

  logic              if_ce_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_stall_o;

  logic              dm_ce_i;
  logic              dm_we_i;
  logic [SelW-1:0]   dm_sel_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [SelW-1:0]   mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  logic              bus_err_o;

  // Arbiter side.
  modport master (
    input  if_ce_i, if_addr_i,
    output if_data_o, if_stall_o,
    input  dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_stall_o,
    output mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output bus_err_o
  );

  // Environment side: CPU pipeline plus memory.
  modport slave (
    output if_ce_i, if_addr_i,
    input  if_data_o, if_stall_o,
    output dm_ce_i, dm_we_i, dm_sel_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_stall_o,
    input  mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  bus_err_o
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Access watchdog: loadable counter that flags when the cycle limit is reached.
module mem_arb_wdog
  import mem_bus_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WdogW-1:0] load_val,
  input  logic             en,
  input  logic [WdogW-1:0] limit,
  output logic             hit_c
);

  logic [WdogW-1:0] cnt;

  // Clear has priority over load, load over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + WdogW'(1);
    end
  end

  assign hit_c = (cnt == limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory port between instruction fetch and data access.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = InstAddrBus,
  parameter int unsigned DATA_W  = InstBus,
  parameter int unsigned TIMEOUT = ArbTimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);

  arb_state_t        state;
  arb_grant_t        last_grant;
  arb_grant_t        grant_c;
  logic              if_done_q;
  logic              dm_done_q;
  logic              if_elig;
  logic              dm_elig;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  mem_ctl_t          grant_ctl;
  logic [DATA_W-1:0] cap_data;
  logic              wdog_hit;
  logic              wdog_load;
  logic              wdog_en;
  logic              wdog_clr;

  assign if_elig = bus.if_ce_i & ~if_done_q;
  assign dm_elig = bus.dm_ce_i & ~dm_done_q;

  // Data port wins a tie unless it won the previous access.
  assign grant_c = (dm_elig && (!if_elig || last_grant != GrantDm)) ? GrantDm : GrantIf;

  // Command presented to memory for the port about to be granted.
  always_comb begin
    grant_addr    = bus.if_addr_i;
    grant_wdata   = '0;
    grant_ctl     = '0;
    grant_ctl.sel = '1;
    if (grant_c == GrantDm) begin
      grant_addr    = bus.dm_addr_i;
      grant_wdata   = bus.dm_wdata_i;
      grant_ctl.we  = bus.dm_we_i;
      grant_ctl.sel = bus.dm_sel_i;
    end
  end

  // An aborted access returns zero; ack takes precedence over the watchdog.
  assign cap_data = bus.mem_ack_i ? bus.mem_rdata_i : '0;

  // The first BUSY cycle counts as one, so the limit hits in the TIMEOUT-th BUSY cycle.
  assign wdog_load = (state == ArbIdle) & (if_elig | dm_elig);
  assign wdog_en   = (state == ArbBusy);
  assign wdog_clr  = (state == ArbBusy) & (bus.mem_ack_i | wdog_hit);

  mem_arb_wdog u_wdog (
    .clk      (clk),
    .rst_n    (rst),
    .clr      (wdog_clr),
    .load     (wdog_load),
    .load_val (WdogW'(1)),
    .en       (wdog_en),
    .limit    (WdogW'(TIMEOUT)),
    .hit_c    (wdog_hit)
  );

  // Arbitration FSM with registered memory command, results and done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ArbIdle;
      last_grant      <= GrantIf;
      if_done_q       <= 1'b0;
      dm_done_q       <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_sel_o   <= '0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.if_data_o   <= '0;
      bus.dm_rdata_o  <= '0;
      bus.bus_err_o   <= 1'b0;
    end else begin
      if_done_q     <= 1'b0;
      dm_done_q     <= 1'b0;
      bus.bus_err_o <= 1'b0;
      if (state == ArbIdle) begin
        if (if_elig || dm_elig) begin
          state           <= ArbBusy;
          last_grant      <= grant_c;
          bus.mem_req_o   <= 1'b1;
          bus.mem_addr_o  <= grant_addr;
          bus.mem_we_o    <= grant_ctl.we;
          bus.mem_sel_o   <= grant_ctl.sel;
          bus.mem_wdata_o <= grant_wdata;
        end
      end else if (bus.mem_ack_i || wdog_hit) begin
        state         <= ArbIdle;
        bus.mem_req_o <= 1'b0;
        bus.bus_err_o <= ~bus.mem_ack_i;
        if (last_grant == GrantIf) begin
          if_done_q     <= 1'b1;
          bus.if_data_o <= cap_data;
        end else begin
          dm_done_q <= 1'b1;
          if (!bus.mem_we_o) begin
            bus.dm_rdata_o <= cap_data;
          end
        end
      end
    end
  end

  assign bus.if_stall_o = bus.if_ce_i & ~if_done_q;
  assign bus.dm_stall_o = bus.dm_ce_i & ~dm_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter with a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  // Transaction-level model state.
  bit          exp_last;   // 1 = data port was served most recently
  logic [31:0] exp_if;
  logic [31:0] exp_dm;

  // What the bench is currently asking for on each CPU port.
  bit          if_ce;
  bit          dm_ce;
  logic [31:0] if_addr;
  bit          dm_we;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input bit ce, input logic [31:0] a);
    if_ce         = ce;
    if_addr       = a;
    bus.if_ce_i   = ce;
    bus.if_addr_i = a;
  endtask

  task automatic drive_dm(input bit ce, input bit we, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] wd);
    dm_ce          = ce;
    dm_we          = we;
    dm_sel         = sel;
    dm_addr        = a;
    dm_wdata       = wd;
    bus.dm_ce_i    = ce;
    bus.dm_we_i    = we;
    bus.dm_sel_i   = sel;
    bus.dm_addr_i  = a;
    bus.dm_wdata_i = wd;
  endtask

  // Act as memory for one access: ack in BUSY cycle lat (never if lat > TO).
  task automatic serve(input bit is_dm, input int lat, input logic [31:0] rd, input int exp_wait);
    int          w;
    int          n;
    bit          acked;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [3:0]  es;
    bit          ewe;
    ea  = is_dm ? dm_addr : if_addr;
    ewe = is_dm ? dm_we : 1'b0;
    es  = is_dm ? dm_sel : 4'hf;
    ewd = is_dm ? dm_wdata : 32'h0;
    // Acks while idle must be ignored.
    bus.mem_ack_i   = 1'($urandom);
    bus.mem_rdata_i = $urandom;
    w = 0;
    while (bus.mem_req_o !== 1'b1 && w < 8) begin
      cyc();
      w++;
      if (bus.mem_req_o !== 1'b1) begin
        chk("idle_err", 32'(bus.bus_err_o), 32'h0);
        bus.mem_ack_i   = 1'($urandom);
        bus.mem_rdata_i = $urandom;
      end
    end
    chk("grant_wait", 32'(w), 32'(exp_wait));
    if (bus.mem_req_o !== 1'b1) begin
      bus.mem_ack_i = 1'b0;
      return;
    end
    n     = 1;
    acked = 1'b0;
    forever begin
      chk("busy_req", 32'(bus.mem_req_o), 32'h1);
      chk("busy_err", 32'(bus.bus_err_o), 32'h0);
      chk("mem_addr", bus.mem_addr_o, ea);
      chk("mem_we", 32'(bus.mem_we_o), 32'(ewe));
      chk("mem_sel", 32'(bus.mem_sel_o), 32'(es));
      chk("mem_wdata", bus.mem_wdata_o, ewd);
      chk("busy_stall", 32'({bus.if_stall_o, bus.dm_stall_o}), 32'({if_ce, dm_ce}));
      if (n == lat) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rd;
      end else begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = $urandom;
      end
      cyc();
      if (n == lat) begin
        acked = 1'b1;
        break;
      end
      if (n == int'(TO)) break;
      n++;
    end
    bus.mem_ack_i = 1'b0;
    // Completion cycle: bus idle, result visible, requester released.
    if (is_dm) begin
      if (!ewe) exp_dm = acked ? rd : 32'h0;
    end else begin
      exp_if = acked ? rd : 32'h0;
    end
    exp_last = is_dm;
    chk("done_req", 32'(bus.mem_req_o), 32'h0);
    chk("done_err", 32'(bus.bus_err_o), 32'(!acked));
    chk("if_data", bus.if_data_o, exp_if);
    chk("dm_rdata", bus.dm_rdata_o, exp_dm);
    chk("done_stall", 32'({bus.if_stall_o, bus.dm_stall_o}), 32'({if_ce & is_dm, dm_ce & ~is_dm}));
  endtask

  // Issue a set of requests and serve them in the order the arbitration rules dictate.
  task automatic run_group(input bit a_if, input bit a_dm, input logic [31:0] ia,
                           input bit dwe, input logic [3:0] dsel, input logic [31:0] da,
                           input logic [31:0] dwd, input int lat_fix, input logic [31:0] rd_fix,
                           input int reissues);
    bit          p_if;
    bit          p_dm;
    bit          c_if;
    bit          c_dm;
    bit          port;
    int          served;
    int          wexp;
    int          lat;
    int          reis;
    logic [31:0] rd;
    drive_if(a_if, ia);
    drive_dm(a_dm, dwe, dsel, da, dwd);
    p_if   = a_if;
    p_dm   = a_dm;
    served = -1;
    reis   = reissues;
    while (p_if || p_dm) begin
      // The port just served sits out the completion cycle.
      c_if = p_if && served != 0;
      c_dm = p_dm && served != 1;
      wexp = 1;
      if (!c_if && !c_dm) begin
        c_if = p_if;
        c_dm = p_dm;
        wexp = 2;
      end
      if (c_if && c_dm) port = !exp_last;
      else              port = c_dm;
      lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, TO + 2));
      rd  = (rd_fix != 0) ? rd_fix : $urandom;
      serve(port, lat, rd, wexp);
      served = port ? 1 : 0;
      if (reis > 0 && $urandom_range(0, 1) == 1) begin
        reis--;
        if (port) drive_dm(1'b1, 1'($urandom), 4'($urandom), $urandom, $urandom);
        else      drive_if(1'b1, $urandom);
      end else if (port) begin
        drive_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        p_dm = 1'b0;
      end else begin
        drive_if(1'b0, 32'h0);
        p_if = 1'b0;
      end
    end
    cyc();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_last = 1'b0;
    exp_if   = 32'h0;
    exp_dm   = 32'h0;
    rst      = 1'b0;
    drive_if(1'b0, 32'h0);
    drive_dm(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    chk("rst_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_sel", 32'(bus.mem_sel_o), 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_if_data", bus.if_data_o, 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    chk("rst_err", 32'(bus.bus_err_o), 32'h0);
    drive_if(1'b1, 32'h40);
    #1;
    chk("rst_stall", 32'({bus.if_stall_o, bus.dm_stall_o}), 32'h2);
    cyc();
    chk("rst_hold_req", 32'(bus.mem_req_o), 32'h0);
    drive_if(1'b0, 32'h0);
    #2 rst = 1'b1;
    cyc();

    // Contention from reset: data read first, then fetch.
    run_group(1'b1, 1'b1, 32'h100, 1'b0, 4'hf, 32'h200, 32'h0, 3, 32'h0, 0);
    // Single-cycle fetch.
    run_group(1'b1, 1'b0, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h3401_1100, 0);
    // Contention with immediate re-requests to exercise alternation.
    run_group(1'b1, 1'b1, 32'h300, 1'b0, 4'hf, 32'h400, 32'h0, 2, 32'h0, 2);
    // Partial write leaves read data alone.
    run_group(1'b0, 1'b1, 32'h0, 1'b1, 4'b0011, 32'h1000, 32'hAABB_CCDD, 3, 32'h0, 0);
    // Fetch never acked: abort, zero data, error pulse.
    run_group(1'b1, 1'b0, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0, int'(TO) + 1, 32'h5555_AAAA, 0);
    // Data read aborted, then data write aborted.
    run_group(1'b0, 1'b1, 32'h0, 1'b0, 4'hf, 32'h2000, 32'h0, int'(TO) + 2, 32'h0, 0);
    run_group(1'b0, 1'b1, 32'h0, 1'b0, 4'hf, 32'h2004, 32'h0, 2, 32'hCAFE_0001, 0);
    run_group(1'b0, 1'b1, 32'h0, 1'b1, 4'hc, 32'h2008, 32'h1234, int'(TO) + 1, 32'h0, 0);
    // Ack in the very cycle the watchdog would fire.
    run_group(1'b1, 1'b0, 32'hC, 1'b0, 4'h0, 32'h0, 32'h0, int'(TO), 32'h1234_5678, 0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      run_group(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 4'($urandom),
                $urandom, $urandom, 0, 32'h0, 2);
    end

    // Reset in the middle of an access.
    drive_if(1'b1, 32'h500);
    drive_dm(1'b1, 1'b0, 4'hf, 32'h600, 32'h0);
    cyc();
    chk("pre_rst_req", 32'(bus.mem_req_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.mem_req_o), 32'h0);
    chk("mid_rst_addr", bus.mem_addr_o, 32'h0);
    chk("mid_rst_sel", 32'(bus.mem_sel_o), 32'h0);
    chk("mid_rst_if_data", bus.if_data_o, 32'h0);
    chk("mid_rst_dm_rdata", bus.dm_rdata_o, 32'h0);
    chk("mid_rst_stall", 32'({bus.if_stall_o, bus.dm_stall_o}), 32'h3);
    #1 rst = 1'b1;
    exp_last = 1'b0;
    exp_if   = 32'h0;
    exp_dm   = 32'h0;
    run_group(1'b1, 1'b1, 32'h500, 1'b0, 4'hf, 32'h600, 32'h0, 2, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one variable-latency memory port between the CPU's instruction-fetch port and its data-memory port, so instructions and data can live in a single unified memory. It sits between `moquanmips` and the memory. It grants one access at a time and runs a req/ack handshake to memory. It returns per-port stall signals so the pipeline freezes until its access completes. A watchdog aborts accesses that never get acknowledged.

## Interface
- `ADDR_W`, 32: address width (matches `InstAddrBus`).
- `DATA_W`, 32: data width (matches `InstBus`).
- `TIMEOUT`, 255: maximum BUSY cycles without ack before abort; legal range 1..65535.

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `if_ce_i` in 1: fetch request pending.
- `if_addr_i` in ADDR_W: fetch address.
- `if_data_o` out DATA_W: fetched instruction, registered.
- `if_stall_o` out 1: fetch not complete.
- `dm_ce_i` in 1: data request pending.
- `dm_we_i` in 1: 1 = write, 0 = read.
- `dm_sel_i` in 4: byte enables.
- `dm_addr_i` in ADDR_W: data address.
- `dm_wdata_i` in DATA_W: write data.
- `dm_rdata_o` out DATA_W: read data, registered.
- `dm_stall_o` out 1: data access not complete.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: write strobe to memory.
- `mem_sel_o` out 4: byte enables to memory.
- `mem_addr_o` out ADDR_W: address to memory.
- `mem_wdata_o` out DATA_W: write data to memory.
- `mem_rdata_i` in DATA_W: read data from memory.
- `mem_ack_i` in 1: memory completion.
- `bus_err_o` out 1: one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, BUSY.
- A port is eligible when its `ce` is high and its `done_q` is low.
- `done_q` is a one-cycle registered flag set on completion. It keeps the just-served request from being re-issued while the CPU advances.
- IDLE, nothing eligible: stay in IDLE.
- IDLE, one port eligible: grant it.
- IDLE, both ports eligible: grant dm, unless `last_grant` is dm, then grant if. This strict alternation prevents starvation.
- On grant:
  - latch `mem_addr_o`, `mem_we_o`, `mem_sel_o`, `mem_wdata_o`; for if, use we=0, sel=4'b1111, wdata=0;
  - set `mem_req_o`, record `last_grant`, clear the watchdog, go to BUSY.
- BUSY: all `mem_*` outputs are held stable; the watchdog increments each cycle.
- BUSY with `mem_ack_i` high:
  - drop `mem_req_o` and set the granted port's `done_q`;
  - capture `mem_rdata_i` into `if_data_o`, or into `dm_rdata_o` on a read only; a write leaves `dm_rdata_o` unchanged;
  - go to IDLE.
- Watchdog reaching TIMEOUT with no ack:
  - drop `mem_req_o`, pulse `bus_err_o`, and set the granted port's `done_q`;
  - load 0 into the granted port's data register (for a dm write, leave `dm_rdata_o` unchanged);
  - go to IDLE.
- Ack and timeout in the same cycle: the ack wins and there is no error.
- `mem_ack_i` outside BUSY is ignored.
- Stall logic, combinational: `if_stall_o` = `if_ce_i` & ~`if_done_q`; `dm_stall_o` = `dm_ce_i` & ~`dm_done_q`.
- A port whose `ce` drops mid-access does not cancel the access. The access completes and its result is discarded by the CPU.

## Timing
- Reset values: all data and address outputs 0; `mem_req_o`, `mem_we_o`, `bus_err_o` 0; `mem_sel_o` 0. State is IDLE, `last_grant` = if, `done_q` flags 0.
- Reset asserted mid-access takes effect immediately: `mem_req_o` drops asynchronously and the in-flight access is lost.
- Access cycle numbering:
  - cycle 0: request seen in IDLE;
  - cycle 1: `mem_req_o` high;
  - cycle k≥1: ack;
  - cycle k+1: data valid, stall low, state IDLE.
- Minimum latency is 2 cycles; stall is high in cycles 0..k.
- Back-to-back: the next grant can be made in the cycle after completion, with `mem_req_o` rising 1 cycle later. The bus idles one cycle between accesses.
- Watchdog abort occurs in cycle TIMEOUT+1 (counted from cycle 1); `bus_err_o` is high exactly that one cycle.

## Structure
- Add to `macros.v`:
  - state encodings `ArbIdle`, `ArbBusy`;
  - grant encodings `GrantIf`, `GrantDm`;
  - `ArbTimeoutDefault` (255).
- Reuse the existing `InstAddrBus` and `InstBus` from `macros.v`.
- One sub-module, `mem_arb_wdog`: a loadable 16-bit counter with clear, enable and compare-to-TIMEOUT output. The FSM, arbitration and data registers stay in the top module.

## Test plan
- Fetch only, ack at cycle 1, addr 0x0000_0004, rdata 0x3401_1100 -> `mem_req_o` high 1 cycle; `if_data_o` = 0x3401_1100 and `if_stall_o` low in cycle 2.
- Fetch and data read both pending from reset, 3-cycle ack -> dm served first, then if. In the next contention, if wins. No port is granted twice in a row while both are eligible.
- Data write, sel 4'b0011, wdata 0xAABB_CCDD -> `mem_we_o`=1 and `mem_sel_o`=4'b0011 held stable until ack; `dm_rdata_o` unchanged.
- No ack, TIMEOUT=4 -> `bus_err_o` pulses in cycle 5; `if_data_o`=0; stall released; next request is serviced normally.
- Ack in the exact timeout cycle -> data captured and `bus_err_o` stays 0.
- `rst` pulled low while BUSY -> `mem_req_o` low immediately, all outputs at reset values. After release, pending requests are re-arbitrated from IDLE.
